gen_pipe_ff: RTL and testbench

Parametrised elastic pipeline register chain with a valid/ready handshake, for use between core pipeline stages and in bus paths.
- DEPTH stages, each holding WIDTH bits of data plus a valid bit.
- Bubbles collapse: a stage refills whenever the stage after it is empty or draining.
- Adds per-stage valid tracking, backpressure, a flush that loads a default value, a global hold, and an occupancy count.

---
 rtl/gen_pipe_ff.sv | 101 ++++++++++
 tb/tb_gen_pipe_ff.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gen_pipe_ff.sv
`default_nettype none
// ============================================================================
// Module   : gen_pipe_ff
// Brief    : Elastic valid/ready register chain with bubble collapse, flush
//            to a default value, global hold and registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module gen_pipe_ff #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       hold,
    input  logic [WIDTH-1:0]           default_val_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] c_occ_one = OCC_W'(1);

    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH:0]   w_adv;
    logic             w_move;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [OCC_W-1:0] r_occ;

    assign w_move = ~hold & ~flush;

    // A stage may advance when it is empty or everything after it drains.
    always_comb begin
        w_adv        = '0;
        w_adv[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_adv[i] = ~w_valid[i] | w_adv[i+1];
        end
    end

    assign in_ready   = w_adv[0] & w_move;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = w_valid[DEPTH-1] & out_ready & w_move;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] w_nxt_data;
        logic             w_nxt_valid;
        logic [WIDTH-1:0] r_data;
        logic             r_valid;

        if (i == 0) begin : g_head
            assign w_nxt_data  = in_data;
            assign w_nxt_valid = in_valid;
        end else begin : g_body
            assign w_nxt_data  = w_data[i-1];
            assign w_nxt_valid = w_valid[i-1];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (flush) begin
                r_data  <= default_val_in;
                r_valid <= 1'b0;
            end else if (!hold && w_adv[i]) begin
                r_data  <= w_nxt_data;
                r_valid <= w_nxt_valid;
            end
        end

        assign w_data[i]  = r_data;
        assign w_valid[i] = r_valid;
    end

    // Bubble collapse moves items without changing the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + c_occ_one;
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - c_occ_one;
        end
    end

    assign out_valid = w_valid[DEPTH-1] & ~hold;
    assign out_data  = w_data[DEPTH-1];
    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_gen_pipe_ff.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_pipe_ff
// Brief    : Scoreboard bench for gen_pipe_ff (WIDTH=32, DEPTH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_pipe_ff;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             hold;
    logic [WIDTH-1:0] default_val_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q [$];

    gen_pipe_ff #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .hold           (hold),
        .default_val_in (default_val_in),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expected item.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && !flush && !hold) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_xfer: got unexpected 0x%0h with empty scoreboard at %0t", out_data, $time);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_xfer: got 0x%0h expected 0x%0h at %0t", out_data, e, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; hold = 1'b0; default_val_in = 32'h13;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_occupancy", {30'b0, occupancy}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        #10 rst = 1'b1;
        tick();

        // Stream of four with free-flowing output
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 32'h11; exp_q.push_back(32'h11); tick();
        chk("s1_occ", {30'b0, occupancy}, 32'd1);
        chk("s1_out_valid", {31'b0, out_valid}, 32'd0);
        in_data = 32'h22; exp_q.push_back(32'h22); tick();
        chk("s2_occ", {30'b0, occupancy}, 32'd2);
        chk("s2_out_valid", {31'b0, out_valid}, 32'd0);
        in_data = 32'h33; exp_q.push_back(32'h33); tick();
        chk("s3_occ", {30'b0, occupancy}, 32'd3);
        chk("s3_out_valid", {31'b0, out_valid}, 32'd1);
        chk("s3_out_data", out_data, 32'h11);
        in_data = 32'h44; exp_q.push_back(32'h44); tick();
        chk("s4_occ", {30'b0, occupancy}, 32'd3);
        chk("s4_out_data", out_data, 32'h22);
        in_valid = 1'b0;
        repeat (3) tick();
        chk("s_drain_occ", {30'b0, occupancy}, 32'd0);

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA0; exp_q.push_back(32'hA0); tick();
        in_data = 32'hA1; exp_q.push_back(32'hA1); tick();
        in_data = 32'hA2; exp_q.push_back(32'hA2); tick();
        in_data = 32'hA3; #1;
        chk("bp_full_occ", {30'b0, occupancy}, 32'd3);
        chk("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1; #1;
        chk("bp_pass_in_ready", {31'b0, in_ready}, 32'd1);
        exp_q.push_back(32'hA3); tick();
        chk("bp_after_occ", {30'b0, occupancy}, 32'd3);
        chk("bp_after_data", out_data, 32'hA1);
        in_valid = 1'b0;
        repeat (3) tick();
        chk("bp_drain_occ", {30'b0, occupancy}, 32'd0);

        // Bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1; exp_q.push_back(32'h1); tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_data = 32'h2; exp_q.push_back(32'h2); tick();
        in_valid = 1'b0; tick();
        chk("bub_occ", {30'b0, occupancy}, 32'd2);
        chk("bub_out_data", out_data, 32'h1);
        chk("bub_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = 32'h3; exp_q.push_back(32'h3); tick();
        chk("bub_full_occ", {30'b0, occupancy}, 32'd3);
        chk("bub_full_in_ready", {31'b0, in_ready}, 32'd0);

        // Flush a full pipe while input is offered
        in_data = 32'h99; out_ready = 1'b1; flush = 1'b1; #1;
        chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
        exp_q.delete();
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_out_data", out_data, 32'h13);
        chk("fl_occ", {30'b0, occupancy}, 32'd0);

        // Hold on a partially full pipe, then hold+flush
        in_valid = 1'b1; in_data = 32'h55; exp_q.push_back(32'h55); tick();
        in_data = 32'h66; exp_q.push_back(32'h66); tick();
        in_valid = 1'b0; tick();
        chk("hd_pre_occ", {30'b0, occupancy}, 32'd2);
        chk("hd_pre_data", out_data, 32'h55);
        hold = 1'b1; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1; #1;
        chk("hd_in_ready", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hd_occ", {30'b0, occupancy}, 32'd2);
            chk("hd_out_data", out_data, 32'h55);
            chk("hd_out_valid", {31'b0, out_valid}, 32'd0);
        end
        flush = 1'b1; exp_q.delete(); tick();
        hold = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("hdfl_occ", {30'b0, occupancy}, 32'd0);
        chk("hdfl_out_data", out_data, 32'h13);
        chk("hdfl_out_valid", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 32'h80; exp_q.push_back(32'h80); tick();
        in_data = 32'h81; exp_q.push_back(32'h81); tick();
        in_data = 32'h82; exp_q.push_back(32'h82); tick();
        chk("ar_pre_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #1 rst = 1'b0; exp_q.delete();
        #1;
        chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_occ", {30'b0, occupancy}, 32'd0);
        chk("ar_out_data", out_data, 32'd0);
        #4 rst = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 32'h90; exp_q.push_back(32'h90); tick();
        in_valid = 1'b0;
        chk("ar_restart_occ", {30'b0, occupancy}, 32'd1);
        tick(); tick();
        chk("ar_restart_data", out_data, 32'h90);
        repeat (3) tick();
        chk("end_queue_empty", exp_q.size(), 32'd0);
        chk("end_occ", {30'b0, occupancy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
